// File: rtl/spi_mem_bridge.sv
// SPI-command-to-memory bridge: decodes write/burst-write, read with prefetch, and streams read data to MISO.
// Optional status command (8'h04) is compiled in when SPI_BRIDGE_STATUS_EN is defined.
module spi_mem_bridge #(
    parameter  int ADDR_BYTES    = 3,
    parameter  int DATA_BYTES    = 2,
    parameter  int RST_CYCLES    = 2,
    parameter  int READ_PREFETCH = 1,
    localparam int ADDR_W        = 8 * ADDR_BYTES,
    localparam int DATA_W        = 8 * DATA_BYTES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_ssel,
    input  logic              spi_data_ready,
    input  logic [7:0]        spi_data_recv,
    input  logic [2:0]        spi_bit_count,
    output logic [7:0]        spi_data_send,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_enable,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_enable,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    input  logic              busy,
    output logic              mem_rst_n
);

    localparam logic [3:0] S_RST      = 4'd0;
    localparam logic [3:0] S_IDLE     = 4'd1;
    localparam logic [3:0] S_WADDR    = 4'd2;
    localparam logic [3:0] S_RADDR    = 4'd3;
    localparam logic [3:0] S_WLEN     = 4'd4;
    localparam logic [3:0] S_WDATA    = 4'd5;
    localparam logic [3:0] S_RD_ISSUE = 4'd6;
    localparam logic [3:0] S_RD_WAIT  = 4'd7;
    localparam logic [3:0] S_SEND     = 4'd8;

    localparam int MAXB = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
    localparam int BCW  = (MAXB > 1) ? $clog2(MAXB) : 1;
    localparam int SIW  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int RCW  = $clog2(RST_CYCLES + 1);

    logic [3:0]        state_q, state_d;
    logic [RCW-1:0]    rcnt_q, rcnt_d;
    logic              mem_rst_n_q, mem_rst_n_d;
    logic [BCW-1:0]    bcnt_q, bcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        wcnt_q, wcnt_d;
    logic [DATA_W-1:0] wsr_q, wsr_d;
    logic              pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_en_q, rd_en_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              rd_valid_q, rd_valid_d;
    logic [7:0]        send_q, send_d;
    logic [SIW-1:0]    sidx_q, sidx_d;
    logic              bc7_q;

    logic              bc7, bc7_rise, byte_ev, abort;
    logic [DATA_W-1:0] word_next;
    logic [SIW-1:0]    nidx;

    always_comb begin
        state_d     = state_q;
        rcnt_d      = rcnt_q;
        mem_rst_n_d = mem_rst_n_q;
        bcnt_d      = bcnt_q;
        addr_d      = addr_q;
        len_d       = len_q;
        wcnt_d      = wcnt_q;
        wsr_d       = wsr_q;
        pend_d      = pend_q;
        ovf_d       = ovf_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = wr_en_q;
        rd_addr_d   = rd_addr_q;
        rd_en_d     = rd_en_q;
        data_d      = data_q;
        rd_valid_d  = rd_valid_q;
        send_d      = send_q;
        sidx_d      = sidx_q;

        bc7       = (spi_bit_count == 3'd7);
        bc7_rise  = bc7 && !bc7_q;
        byte_ev   = spi_data_ready && !spi_ssel;
        word_next = (wsr_q << 8) | DATA_W'(spi_data_recv);
        nidx      = (sidx_q == '0) ? '0 : sidx_q - SIW'(1);
        // A read whose enable is already up must finish its handshake, so it is not abortable.
        abort     = spi_ssel && ((state_q inside {S_WADDR, S_RADDR, S_WLEN, S_WDATA, S_SEND}) ||
                                 (state_q == S_RD_ISSUE && !rd_en_q));

        // Commit engine runs independently of command decode.
        if (wr_en_q) begin
            if (busy) begin
                wr_en_d = 1'b0;
                pend_d  = 1'b0;
            end
        end else if (pend_q && !busy) begin
            wr_en_d = 1'b1;
        end

        if (abort) begin
            state_d = S_IDLE;
            bcnt_d  = '0;
        end else begin
            case (state_q)
                S_RST: begin
                    if (rcnt_q == RCW'(RST_CYCLES - 1)) begin
                        mem_rst_n_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        rcnt_d = rcnt_q + RCW'(1);
                    end
                end
                S_IDLE: begin
                    if (byte_ev) begin
                        case (spi_data_recv)
                            8'h01: begin state_d = S_WADDR; bcnt_d = '0; end
                            8'h02: begin state_d = S_RADDR; bcnt_d = '0; end
                            8'h03: begin
                                state_d = S_SEND;
                                sidx_d  = SIW'(DATA_BYTES - 1);
                                send_d  = rd_valid_q ? data_q[DATA_W-1 -: 8] : 8'hFF;
                            end
`ifdef SPI_BRIDGE_STATUS_EN
                            8'h04: begin
                                send_d = {ovf_q, pend_q, rd_valid_q, 5'b0};
                                ovf_d  = 1'b0;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                S_WADDR, S_RADDR: begin
                    if (byte_ev) begin
                        addr_d = (addr_q << 8) | ADDR_W'(spi_data_recv);
                        if (bcnt_q == BCW'(ADDR_BYTES - 1)) begin
                            bcnt_d = '0;
                            if (state_q == S_WADDR) begin
                                state_d = S_WLEN;
                            end else begin
                                state_d    = S_RD_ISSUE;
                                rd_valid_d = 1'b0;
                            end
                        end else begin
                            bcnt_d = bcnt_q + BCW'(1);
                        end
                    end
                end
                S_WLEN: begin
                    if (byte_ev) begin
                        len_d   = spi_data_recv;
                        wcnt_d  = 8'd0;
                        bcnt_d  = '0;
                        state_d = S_WDATA;
                    end
                end
                S_WDATA: begin
                    if (byte_ev) begin
                        wsr_d = word_next;
                        if (bcnt_q == BCW'(DATA_BYTES - 1)) begin
                            bcnt_d = '0;
                            // Single holding slot: a word arriving while one is still pending is lost.
                            if (!pend_q) begin
                                pend_d    = 1'b1;
                                wr_addr_d = addr_q;
                                wr_data_d = word_next;
                            end else begin
                                ovf_d = 1'b1;
                            end
                            addr_d = addr_q + ADDR_W'(1);
                            if (wcnt_q == len_q) state_d = S_IDLE;
                            else                 wcnt_d  = wcnt_q + 8'd1;
                        end else begin
                            bcnt_d = bcnt_q + BCW'(1);
                        end
                    end
                end
                S_RD_ISSUE: begin
                    if (rd_en_q) begin
                        if (rd_ready) begin
                            rd_en_d    = 1'b0;
                            data_d     = rd_data;
                            rd_valid_d = 1'b1;
                            state_d    = S_IDLE;
                        end else if (busy) begin
                            rd_en_d = 1'b0;
                            state_d = S_RD_WAIT;
                        end
                    end else if (!pend_q && !busy) begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = addr_q;
                    end
                end
                S_RD_WAIT: begin
                    if (rd_ready) begin
                        data_d     = rd_data;
                        rd_valid_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
                S_SEND: begin
                    if (bc7_rise) begin
                        sidx_d = nidx;
                        send_d = rd_valid_q ? 8'(data_q >> (8 * nidx)) : 8'hFF;
                        if (nidx == '0) begin
                            if (READ_PREFETCH != 0 && rd_valid_q) begin
                                addr_d  = addr_q + ADDR_W'(1);
                                state_d = S_RD_ISSUE;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RST;
            rcnt_q      <= '0;
            mem_rst_n_q <= 1'b0;
            bcnt_q      <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            wcnt_q      <= '0;
            wsr_q       <= '0;
            pend_q      <= 1'b0;
            ovf_q       <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            rd_en_q     <= 1'b0;
            data_q      <= '0;
            rd_valid_q  <= 1'b0;
            send_q      <= 8'hFF;
            sidx_q      <= '0;
            bc7_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rcnt_q      <= rcnt_d;
            mem_rst_n_q <= mem_rst_n_d;
            bcnt_q      <= bcnt_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            wcnt_q      <= wcnt_d;
            wsr_q       <= wsr_d;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
            rd_addr_q   <= rd_addr_d;
            rd_en_q     <= rd_en_d;
            data_q      <= data_d;
            rd_valid_q  <= rd_valid_d;
            send_q      <= send_d;
            sidx_q      <= sidx_d;
            bc7_q       <= bc7;
        end
    end

    assign spi_data_send = send_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign wr_enable     = wr_en_q;
    assign rd_addr       = rd_addr_q;
    assign rd_enable     = rd_en_q;
    assign mem_rst_n     = mem_rst_n_q;

endmodule
